// File: rtl/blink_arbiter_pkg.sv
// blink_arbiter_pkg
//  Shared definitions for the blink arbiter: FSM state encodings and the
//  helper that sizes the hold-off counter.
package blink_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Width of a counter that can hold the value HOLDOFF.
  function automatic int hold_w(input int holdoff);
    return (holdoff < 1) ? 1 : $clog2(holdoff + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
//  Combinational round-robin picker. Returns the first set bit of pending,
//  searching ptr+1, ptr+2, ... wrapping modulo NUM_REQ, so the requester at
//  ptr itself is checked last.
//  Ports:
//   pending  in   NUM_REQ  request vector
//   ptr      in   IDW      last served requester
//   any      out  1        at least one request present
//   idx      out  IDW      chosen requester (holds ptr when any=0)
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [IDW-1:0]     ptr,
  output logic               any,
  output logic [IDW-1:0]     idx
);

  localparam logic [IDW:0] NREQ = (IDW+1)'(NUM_REQ);

  // ptr + k mod NUM_REQ; one extra bit covers the sum before the wrap.
  function automatic logic [IDW-1:0] wrap(input logic [IDW-1:0] p, input int k);
    logic [IDW:0] s;
    s = {1'b0, p} + (IDW+1)'(k);
    if (s >= NREQ) s = s - NREQ;
    return s[IDW-1:0];
  endfunction

  always_comb begin
    any = 1'b0;
    idx = ptr;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!any && pending[wrap(ptr, k)]) begin
        any = 1'b1;
        idx = wrap(ptr, k);
      end
    end
  end

endmodule

// File: rtl/blink_arbiter.sv
// blink_arbiter
//  Shares one blinker's switch input among NUM_REQ requesters. Rising edges
//  of req are captured as pending toggle requests and served round-robin,
//  one 1-cycle toggle pulse per grant, with at least HOLDOFF idle cycles
//  between pulses.
//  Ports:
//   clk          in   1        system clock
//   rst          in   1        async reset, active low
//   req          in   NUM_REQ  level requests, rising edge = one request
//   enable       in   1        0 = capture only, no new grants
//   toggle       out  1        1-cycle pulse to the blinker
//   grant_id     out  IDW      requester of current/last pulse
//   grant_valid  out  1        high with toggle
//   pending      out  NUM_REQ  captured, unserved requests
//   busy         out  1        FSM in FIRE or HOLD
module blink_arbiter
  import blink_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2,
  parameter int HOLDOFF = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  output logic               toggle,
  output logic [IDW-1:0]     grant_id,
  output logic               grant_valid,
  output logic [NUM_REQ-1:0] pending,
  output logic               busy
);

  localparam int             HCW       = hold_w(HOLDOFF);
  localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLDOFF);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] req_dly_q, req_dly_d;
  logic               armed_q, armed_d;
  logic [NUM_REQ-1:0] pend_q, pend_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [HCW-1:0]     hold_q, hold_d;
  logic               toggle_q, toggle_d;
  logic               gv_q, gv_d;
  logic [IDW-1:0]     gid_q, gid_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] rise, clr;
  logic               pick_any;
  logic [IDW-1:0]     pick_idx;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_pick (
    .pending (pend_q),
    .ptr     (ptr_q),
    .any     (pick_any),
    .idx     (pick_idx)
  );

  always_comb begin
    // The first edge after reset only samples req, so a level already high
    // coming out of reset is not mistaken for a fresh request.
    armed_d   = 1'b1;
    req_dly_d = req;
    rise      = req & ~req_dly_q & {NUM_REQ{armed_q}};
    clr       = '0;
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gid_d     = gid_q;
    toggle_d  = 1'b0;
    gv_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable && pick_any) begin
          state_d       = ST_FIRE;
          clr[pick_idx] = 1'b1;
          toggle_d      = 1'b1;
          gv_d          = 1'b1;
          gid_d         = pick_idx;
        end
      end
      ST_FIRE: begin
        ptr_d = gid_q;
        // The IDLE cycle before the next FIRE is itself one of the HOLDOFF
        // idle cycles, so HOLD only covers the remaining HOLDOFF-1.
        if (HOLDOFF > 1) begin
          state_d = ST_HOLD;
          hold_d  = HOLD_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        hold_d = hold_q - 1'b1;
        if (hold_d == HCW'(1)) begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A rise landing on the same edge as its clear wins: request stays.
    pend_d = (pend_q & ~clr) | rise;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      req_dly_q <= '0;
      armed_q   <= 1'b0;
      pend_q    <= '0;
      ptr_q     <= IDW'(NUM_REQ - 1);
      hold_q    <= '0;
      toggle_q  <= 1'b0;
      gv_q      <= 1'b0;
      gid_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_dly_q <= req_dly_d;
      armed_q   <= armed_d;
      pend_q    <= pend_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      toggle_q  <= toggle_d;
      gv_q      <= gv_d;
      gid_q     <= gid_d;
      busy_q    <= busy_d;
    end
  end

  assign toggle      = toggle_q;
  assign grant_valid = gv_q;
  assign grant_id    = gid_q;
  assign pending     = pend_q;
  assign busy        = busy_q;

endmodule
